// File: rtl/rs_input_conditioner_if.sv
// Signal bundle between the pushbutton front end and the RS latch driver.
// The master side drives the raw buttons and observes the conditioned
// outputs; the slave side is the conditioner itself.
interface rs_input_conditioner_if;
    logic set_raw;
    logic reset_raw;
    logic s_out;
    logic r_out;
    logic busy;
    logic conflict;
    logic shadow_q;

    modport master (
        output set_raw,
        output reset_raw,
        input  s_out,
        input  r_out,
        input  busy,
        input  conflict,
        input  shadow_q
    );

    modport slave (
        input  set_raw,
        input  reset_raw,
        output s_out,
        output r_out,
        output busy,
        output conflict,
        output shadow_q
    );
endinterface

// File: rtl/rs_input_conditioner.sv
// rs_input_conditioner: turns two bouncy asynchronous pushbuttons into clean,
// mutually exclusive, fixed-width r/s pulses for a downstream RS latch, and
// keeps a shadow copy of the q value the latch should hold.
// Optional feature macro: RSCOND_INIT_PULSE_EN -- when defined, reset parks the
// FSM in DRIVE_R so the latch is forced to q=0 during and just after reset.
module rs_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input logic                   clk,
    input logic                   rst,
    rs_input_conditioner_if.slave bus
);

    // Channel index 0 is the set button, index 1 the reset button.
    localparam int CH_S = 0;
    localparam int CH_R = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

`ifdef RSCOND_INIT_PULSE_EN
    localparam state_t RESET_STATE = DRIVE_R;
    localparam logic   RESET_DRIVE = 1'b1;
`else
    localparam state_t RESET_STATE = IDLE;
    localparam logic   RESET_DRIVE = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DB_LIMIT   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0]       PULSE_LAST = 4'(PULSE_CYCLES - 1);

    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       db_q, db_d;
    logic [1:0]       db_prev_q, db_prev_d;
    logic [1:0]       req_q, req_d;
    logic [1:0]       req_clr;
    logic [1:0]       rise;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    state_t           state_q, state_d;
    logic [3:0]       pulse_cnt_q, pulse_cnt_d;
    logic             s_out_q, s_out_d;
    logic             r_out_q, r_out_d;
    logic             busy_q, busy_d;
    logic             conflict_q, conflict_d;
    logic             shadow_q, shadow_d;

    assign raw  = {bus.reset_raw, bus.set_raw};
    assign rise = db_q & ~db_prev_q;

    // Synchronize both buttons and debounce: the level only flips after it has disagreed with db for DEBOUNCE_CYCLES straight cycles.
    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        for (int c = 0; c < 2; c++) begin
            cnt_d[c] = '0;
            if (sync2_q[c] != db_q[c]) begin
                if (cnt_q[c] + CNT_W'(1) == DB_LIMIT) begin
                    db_d[c] = ~db_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    // Command FSM: accept one pending request in IDLE (reset wins ties), drive it for PULSE_CYCLES, then force a one-cycle gap.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        req_clr     = 2'b00;
        conflict_d  = 1'b0;
        shadow_d    = shadow_q;
        case (state_q)
            IDLE: begin
                if (req_q[CH_R]) begin
                    state_d       = DRIVE_R;
                    pulse_cnt_d   = 4'd0;
                    req_clr[CH_R] = 1'b1;
                    shadow_d      = 1'b0;
                    if (req_q[CH_S]) begin
                        req_clr[CH_S] = 1'b1;
                        conflict_d    = 1'b1;
                    end
                end else if (req_q[CH_S]) begin
                    state_d       = DRIVE_S;
                    pulse_cnt_d   = 4'd0;
                    req_clr[CH_S] = 1'b1;
                    shadow_d      = 1'b1;
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d = GAP;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 4'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d   = (req_q & ~req_clr) | rise;
        s_out_d = (state_d == DRIVE_S);
        r_out_d = (state_d == DRIVE_R);
        busy_d  = (state_d != IDLE);
    end

    // All state and every output is a flop; synchronous reset returns the block to its reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            db_q        <= 2'b00;
            db_prev_q   <= 2'b00;
            req_q       <= 2'b00;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            state_q     <= RESET_STATE;
            pulse_cnt_q <= 4'd0;
            s_out_q     <= 1'b0;
            r_out_q     <= RESET_DRIVE;
            busy_q      <= RESET_DRIVE;
            conflict_q  <= 1'b0;
            shadow_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_prev_q   <= db_prev_d;
            req_q       <= req_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            s_out_q     <= s_out_d;
            r_out_q     <= r_out_d;
            busy_q      <= busy_d;
            conflict_q  <= conflict_d;
            shadow_q    <= shadow_d;
        end
    end

    assign bus.s_out    = s_out_q;
    assign bus.r_out    = r_out_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;
    assign bus.shadow_q = shadow_q;

endmodule

// File: tb/tb_rs_input_conditioner.sv
// Testbench for rs_input_conditioner: directed scenarios with literal
// expectations plus a long randomized run, all checked every cycle against a
// timeline-based behavioural model of the conditioner.
module tb_rs_input_conditioner;

    localparam int D  = 4;
    localparam int P  = 2;
    localparam int HN = 8192;

`ifdef RSCOND_INIT_PULSE_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    rs_input_conditioner_if bus ();

    rs_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .PULSE_CYCLES    (P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model state: raw sample history per channel, debounced level, when it
    // last flipped / last rose, pending requests, and the last issued command.
    bit hist [2][HN];
    bit mdb [2];
    int lastFlip [2];
    int roseAt [2];
    bit pend [2];
    int n = -1;
    int lastIssue = -100;
    int lastType = 0;
    bit mshadow = 0;
    bit mconf = 0;
    bit eS, eR, eBusy, eConf, eShadow;
    bit modelValid = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b (edge %0d)", name, act, exp, n);
        end
    endtask

    function automatic bit histAt(input int c, input int idx);
        if (idx < 0) return 1'b0;
        return hist[c][idx];
    endfunction

    // Advance the model by one rising edge with the inputs that edge sampled.
    task automatic modelStep(input bit rv, input bit sv, input bit rrv);
        bit allDiff;
        n++;
        if (rv) begin
            for (int c = 0; c < 2; c++) begin
                hist[c][n] = 1'b0;
                if (n > 0) hist[c][n-1] = 1'b0;
                mdb[c]      = 1'b0;
                lastFlip[c] = n;
                roseAt[c]   = -100;
                pend[c]     = 1'b0;
            end
            mshadow = 1'b0;
            mconf   = 1'b0;
            if (INIT_EN) begin
                lastIssue = n;
                lastType  = 1;
            end else begin
                lastIssue = -100;
            end
        end else begin
            hist[0][n] = sv;
            hist[1][n] = rrv;
            mconf = 1'b0;
            if (n >= lastIssue + P + 2) begin
                if (pend[1]) begin
                    lastIssue = n;
                    lastType  = 1;
                    pend[1]   = 1'b0;
                    mshadow   = 1'b0;
                    if (pend[0]) begin
                        pend[0] = 1'b0;
                        mconf   = 1'b1;
                    end
                end else if (pend[0]) begin
                    lastIssue = n;
                    lastType  = 0;
                    pend[0]   = 1'b0;
                    mshadow   = 1'b1;
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (roseAt[c] == n - 1) pend[c] = 1'b1;
            end
            for (int c = 0; c < 2; c++) begin
                if (n - lastFlip[c] >= D) begin
                    allDiff = 1'b1;
                    for (int j = 0; j < D; j++) begin
                        if (histAt(c, n - 2 - j) == mdb[c]) allDiff = 1'b0;
                    end
                    if (allDiff) begin
                        mdb[c]      = ~mdb[c];
                        lastFlip[c] = n;
                        if (mdb[c]) roseAt[c] = n;
                    end
                end
            end
        end
        eS      = (n >= lastIssue) && (n <= lastIssue + P - 1) && (lastType == 0);
        eR      = (n >= lastIssue) && (n <= lastIssue + P - 1) && (lastType == 1);
        eBusy   = (n >= lastIssue) && (n <= lastIssue + P);
        eConf   = mconf;
        eShadow = mshadow;
        modelValid = 1'b1;
    endtask

    // Drive one cycle of inputs away from the edge, then step the model just after the edge.
    task automatic applyStimulus(input bit rv, input bit sv, input bit rrv);
        @(negedge clk);
        rst           = rv;
        bus.set_raw   = sv;
        bus.reset_raw = rrv;
        @(posedge clk);
        #1;
        modelStep(rv, sv, rrv);
    endtask

    // Compare every DUT output against the model once per cycle on the falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("s_out", bus.s_out, eS);
            checkOutput("r_out", bus.r_out, eR);
            checkOutput("busy", bus.busy, eBusy);
            checkOutput("conflict", bus.conflict, eConf);
            checkOutput("shadow_q", bus.shadow_q, eShadow);
            checkOutput("excl", bus.s_out & bus.r_out, 1'b0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit curS, curR;
        int holdS, holdR;
        rst           = 1'b1;
        bus.set_raw   = 1'b0;
        bus.reset_raw = 1'b0;

        // Init: reset for three cycles, then the optional init pulse drains.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("rst_s", bus.s_out, 1'b0);
            checkOutput("rst_shadow", bus.shadow_q, 1'b0);
            checkOutput("rst_r", bus.r_out, INIT_EN);
            checkOutput("rst_busy", bus.busy, INIT_EN);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("init_r1", bus.r_out, INIT_EN);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("init_gap_r", bus.r_out, 1'b0);
        checkOutput("init_gap_busy", bus.busy, INIT_EN);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("init_idle", bus.busy, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Clean set press held 20 cycles.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("set_s", bus.s_out, (i == 7) || (i == 8));
            checkOutput("set_busy", bus.busy, (i >= 7) && (i <= 9));
            checkOutput("set_shadow", bus.shadow_q, i >= 7);
            checkOutput("set_r", bus.r_out, 1'b0);
        end
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Bounce: toggle every 2 cycles for 16 cycles, then settle low.
        for (int i = 0; i < 26; i++) begin
            applyStimulus(1'b0, (i < 16) && ((i / 2) % 2 == 0), 1'b0);
            checkOutput("bounce_s", bus.s_out, 1'b0);
            checkOutput("bounce_busy", bus.busy, 1'b0);
            checkOutput("bounce_shadow", bus.shadow_q, 1'b1);
        end

        // Simultaneous press: reset wins, conflict pulses.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("sim_r", bus.r_out, (i == 7) || (i == 8));
            checkOutput("sim_conflict", bus.conflict, i == 7);
            checkOutput("sim_s", bus.s_out, 1'b0);
            if (i >= 7) checkOutput("sim_shadow", bus.shadow_q, 1'b0);
        end
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Queued: reset request becomes pending during DRIVE_S and waits for the gap.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, i >= 2);
            checkOutput("q_s", bus.s_out, (i == 7) || (i == 8));
            checkOutput("q_r", bus.r_out, (i == 11) || (i == 12));
            checkOutput("q_shadow", bus.shadow_q, (i >= 7) && (i <= 10));
        end
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Mid-pulse reset with a reset request pending.
        for (int i = 0; i < 31; i++) begin
            applyStimulus(i == 9, i <= 8, (i >= 2) && (i <= 7));
            if (i == 8) checkOutput("mid_s_before", bus.s_out, 1'b1);
            if (i == 9) begin
                checkOutput("mid_s", bus.s_out, 1'b0);
                checkOutput("mid_shadow", bus.shadow_q, 1'b0);
                checkOutput("mid_r", bus.r_out, INIT_EN);
            end
            if (i >= 15) begin
                checkOutput("mid_idle_r", bus.r_out, 1'b0);
                checkOutput("mid_idle_busy", bus.busy, 1'b0);
            end
        end

        // Randomized run: random hold lengths mix glitches with real presses, rare resets.
        curS  = 1'b0;
        curR  = 1'b0;
        holdS = 3;
        holdR = 5;
        for (int i = 0; i < 3000; i++) begin
            if (holdS == 0) begin
                curS  = ~curS;
                holdS = $urandom_range(1, 12);
            end else begin
                holdS--;
            end
            if (holdR == 0) begin
                curR  = ~curR;
                holdR = $urandom_range(1, 12);
            end else begin
                holdR--;
            end
            applyStimulus($urandom_range(0, 299) == 0, curS, curR);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
